// File: rtl/data_memory_unit_if.sv
// Purpose: LSQ-issue request bundle and response-FIFO head bundle for the data memory unit.
// Latency: none (wiring only).
// Backpressure: reqValid/reqReady on the request side, respValid/respReady on the response side.
interface data_memory_unit_if;
    // request side: one LSQ issue per cycle
    logic        reqValid;
    logic        reqReady;
    logic [31:0] pcIn;
    logic [5:0]  ROBNumIn;
    logic [5:0]  destRegIn;
    logic [31:0] addressIn;
    logic        loadStore;
    logic        storeSizeIn;
    logic [31:0] swDataIn;
    logic        fromLSQ;
    logic [31:0] lwDataIn;

    // response side: head of the in-order response queue
    logic        respValid;
    logic        respReady;
    logic [31:0] pcOut;
    logic [5:0]  ROBNumOut;
    logic [5:0]  destRegOut;
    logic [0:0]  isStoreOut;
    logic [31:0] loadDataOut;

    // issuing side (LSQ) and consumer of responses
    modport master (
        output reqValid, pcIn, ROBNumIn, destRegIn, addressIn, loadStore,
               storeSizeIn, swDataIn, fromLSQ, lwDataIn, respReady,
        input  reqReady, respValid, pcOut, ROBNumOut, destRegOut, isStoreOut,
               loadDataOut
    );

    // the data memory unit itself
    modport slave (
        input  reqValid, pcIn, ROBNumIn, destRegIn, addressIn, loadStore,
               storeSizeIn, swDataIn, fromLSQ, lwDataIn, respReady,
        output reqReady, respValid, pcOut, ROBNumOut, destRegOut, isStoreOut,
               loadDataOut
    );
endinterface

// File: rtl/data_memory_unit.sv
// Purpose: byte-addressed data array serving LSQ loads/stores, responses queued in order.
// Latency: store / forwarded load visible at N+1, memory load at N+2 after acceptance.
// Backpressure: reqReady drops once queued plus in-flight responses would fill the FIFO.
module data_memory_unit #(
    parameter int MEM_BYTES  = 1024,
    parameter int RESP_DEPTH = 4
) (
    input logic              clk,
    input logic              rstn,
    data_memory_unit_if.slave bus
);
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int unsigned DEPTH_M1 = RESP_DEPTH - 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic        is_store;
        logic [31:0] data;
    } resp_t;

    logic [7:0]       mem [MEM_BYTES];
    resp_t            fifo [RESP_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             s2_vld;
    resp_t            s2_resp;

    logic             accept;
    logic             push_s1;
    logic             cap_s2;
    logic             pop;
    logic [AW-1:0]    byte_addr;
    logic [AW-3:0]    word_idx;
    logic [31:0]      rd_word;
    logic [7:0]       rd_byte;
    logic [31:0]      load_data;
    resp_t            req_resp;
    resp_t            head;
    logic [PTR_W-1:0] wr_idx0;
    logic [PTR_W-1:0] wr_idx1;
    logic             unused_addr;

    // ring index helper so RESP_DEPTH need not be a power of two
    function automatic logic [PTR_W-1:0] ring_idx(input int unsigned v);
        int unsigned r;
        r = v % RESP_DEPTH;
        return PTR_W'(r);
    endfunction

    // address decode: high address bits alias onto the array
    assign byte_addr   = bus.addressIn[AW-1:0];
    assign word_idx    = byte_addr[AW-1:2];
    assign unused_addr = ^bus.addressIn[31:AW];

    // the read sees every store committed at earlier edges, so a load right behind a store gets fresh data
    assign rd_word   = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                        mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};
    assign rd_byte   = mem[byte_addr];
    assign load_data = bus.storeSizeIn ? {{24{rd_byte[7]}}, rd_byte} : rd_word;

    // S1 is the accepting cycle itself; nothing of it survives the edge except the S2 capture,
    // so only FIFO occupancy and the S2 slot need to be reserved against overflow
    assign bus.reqReady = rstn && ((32'(count) + 32'(s2_vld)) <= DEPTH_M1);
    assign accept       = bus.reqValid && bus.reqReady;
    assign push_s1      = accept && (bus.loadStore || bus.fromLSQ);
    assign cap_s2       = accept && !bus.loadStore && !bus.fromLSQ;
    assign pop          = bus.respValid && bus.respReady;

    assign req_resp.pc       = bus.pcIn;
    assign req_resp.rob      = bus.ROBNumIn;
    assign req_resp.dest     = bus.destRegIn;
    assign req_resp.is_store = bus.loadStore;
    assign req_resp.data     = bus.loadStore ? 32'h0 :
                               (bus.fromLSQ ? bus.lwDataIn : load_data);

    // S2 entry goes in first (older), the S1 entry lands right behind it
    assign wr_idx0 = ring_idx(32'(rd_ptr) + 32'(count));
    assign wr_idx1 = ring_idx(32'(rd_ptr) + 32'(count) + 32'(s2_vld));

    // data array: cleared on reset, written by accepted stores
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= 8'h0;
            end
        end else if (accept && bus.loadStore) begin
            if (bus.storeSizeIn) begin
                mem[byte_addr] <= bus.swDataIn[7:0];
            end else begin
                mem[{word_idx, 2'd0}] <= bus.swDataIn[7:0];
                mem[{word_idx, 2'd1}] <= bus.swDataIn[15:8];
                mem[{word_idx, 2'd2}] <= bus.swDataIn[23:16];
                mem[{word_idx, 2'd3}] <= bus.swDataIn[31:24];
            end
        end
    end

    // S2 register: holds a memory load's read result for one cycle before it enters the FIFO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_vld  <= 1'b0;
            s2_resp <= '0;
        end else begin
            s2_vld <= cap_s2;
            if (cap_s2) begin
                s2_resp <= req_resp;
            end
        end
    end

    // FIFO occupancy and read pointer: up to two pushes and one pop per edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= CNT_W'(32'(count) + 32'(s2_vld) + 32'(push_s1) - 32'(pop));
            if (pop) begin
                rd_ptr <= ring_idx(32'(rd_ptr) + 32'd1);
            end
        end
    end

    // FIFO storage: entries are only observable through count, so they need no reset
    always_ff @(posedge clk) begin
        if (s2_vld) begin
            fifo[wr_idx0] <= s2_resp;
        end
        if (push_s1) begin
            fifo[wr_idx1] <= req_resp;
        end
    end

    // head is registered state only (no bypass), forced to zero when the queue is empty
    assign bus.respValid   = (count != '0);
    assign head            = bus.respValid ? fifo[rd_ptr] : '0;
    assign bus.pcOut       = head.pc;
    assign bus.ROBNumOut   = head.rob;
    assign bus.destRegOut  = head.dest;
    assign bus.isStoreOut  = head.is_store;
    assign bus.loadDataOut = head.data;
endmodule

// File: tb/tb_data_memory_unit.sv
// Purpose: self-checking bench for data_memory_unit against an in-order byte-array model.
// Latency: directed scenarios check exact response cycles; random traffic checks order/data.
// Backpressure: exercises respReady stalls, reqReady throttling and reset mid-flight.
module tb_data_memory_unit;
    localparam int MEM_BYTES  = 1024;
    localparam int RESP_DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  rob;
        logic [5:0]  dest;
        logic        is_store;
        logic [31:0] data;
    } rsp_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    data_memory_unit_if bus();

    data_memory_unit #(.MEM_BYTES(MEM_BYTES), .RESP_DEPTH(RESP_DEPTH)) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] mmem [MEM_BYTES];
    rsp_t       exp_q[$];
    rsp_t       got_q[$];

    function automatic rsp_t head_now();
        return {bus.pcOut, bus.ROBNumOut, bus.destRegOut, bus.isStoreOut, bus.loadDataOut};
    endfunction

    // reference model: program-order memory; every accepted request yields one response in order
    task automatic model_accept();
        int unsigned a;
        int unsigned w;
        rsp_t r;
        a = bus.addressIn % MEM_BYTES;
        w = a & ~32'd3;
        r.pc = bus.pcIn;
        r.rob = bus.ROBNumIn;
        r.dest = bus.destRegIn;
        r.is_store = bus.loadStore;
        r.data = 32'h0;
        if (bus.loadStore) begin
            if (bus.storeSizeIn) mmem[a] = bus.swDataIn[7:0];
            else for (int k = 0; k < 4; k++) mmem[w + k] = bus.swDataIn[8*k +: 8];
        end else if (bus.fromLSQ) begin
            r.data = bus.lwDataIn;
        end else if (bus.storeSizeIn) begin
            r.data = {{24{mmem[a][7]}}, mmem[a]};
        end else begin
            r.data = {mmem[w + 3], mmem[w + 2], mmem[w + 1], mmem[w]};
        end
        exp_q.push_back(r);
    endtask

    task automatic model_reset();
        for (int i = 0; i < MEM_BYTES; i++) mmem[i] = 8'h0;
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic drive(input logic v, input logic ls, input logic sz, input logic fwd,
                         input logic [31:0] addr, input logic [31:0] sw, input logic [31:0] lw,
                         input logic [31:0] pc, input logic [5:0] rob, input logic [5:0] dest);
        bus.reqValid    = v;
        bus.loadStore   = ls;
        bus.storeSizeIn = sz;
        bus.fromLSQ     = fwd;
        bus.addressIn   = addr;
        bus.swDataIn    = sw;
        bus.lwDataIn    = lw;
        bus.pcIn        = pc;
        bus.ROBNumIn    = rob;
        bus.destRegIn   = dest;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 6'd0, 6'd0);
    endtask

    // one clock: record handshakes at the falling edge, return 1 time unit after the rising edge
    task automatic step();
        @(negedge clk);
        if (bus.reqValid && bus.reqReady) model_accept();
        if (bus.respValid && bus.respReady) got_q.push_back(head_now());
        @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int n;
        idle();
        bus.respReady = 1'b1;
        n = 0;
        while (got_q.size() != exp_q.size() && n < 60) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        idle();
        bus.respReady = 1'b0;
        model_reset();
        #2;
        checks++;
        if (bus.reqReady !== 1'b0 || bus.respValid !== 1'b0 || head_now() !== '0) begin
            errors++;
            $display("FAIL reset_hold got rdy=%b vld=%b head=%h want 0 0 0",
                     bus.reqReady, bus.respValid, head_now());
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.reqReady !== 1'b1 || bus.respValid !== 1'b0 || head_now() !== '0) begin
            errors++;
            $display("FAIL reset_release got rdy=%b vld=%b head=%h want 1 0 0",
                     bus.reqReady, bus.respValid, head_now());
        end
    endtask

    task automatic test_store_load();
        rsp_t want;
        exp_q.delete(); got_q.delete();
        bus.respReady = 1'b1;
        drive(1, 1, 0, 0, 32'h10, 32'hDEADBEEF, 32'h0, 32'h4, 6'd3, 6'd0);
        step();
        want = '{32'h4, 6'd3, 6'd0, 1'b1, 32'h0};
        checks++;
        if (bus.respValid !== 1'b1 || head_now() !== want) begin
            errors++;
            $display("FAIL store_resp_n1 got v=%b %h want v=1 %h", bus.respValid, head_now(), want);
        end
        drive(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h8, 6'd4, 6'd7);
        step();
        idle();
        checks++;
        if (bus.respValid !== 1'b0) begin
            errors++;
            $display("FAIL load_not_at_n1 got v=%b want v=0", bus.respValid);
        end
        step();
        want = '{32'h8, 6'd4, 6'd7, 1'b0, 32'hDEADBEEF};
        checks++;
        if (bus.respValid !== 1'b1 || head_now() !== want) begin
            errors++;
            $display("FAIL load_resp_n2 got v=%b %h want v=1 %h", bus.respValid, head_now(), want);
        end
        step();
        checks++;
        if (bus.respValid !== 1'b0 || head_now() !== '0) begin
            errors++;
            $display("FAIL empty_zero got v=%b %h want v=0 0", bus.respValid, head_now());
        end
    endtask

    task automatic test_byte();
        exp_q.delete(); got_q.delete();
        bus.respReady = 1'b1;
        drive(1, 1, 1, 0, 32'h13, 32'h00000080, 32'h0, 32'h2C, 6'd1, 6'd0);
        step();
        drive(1, 0, 1, 0, 32'h13, 32'h0, 32'h0, 32'h30, 6'd2, 6'd3);
        step();
        drive(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h34, 6'd5, 6'd4);
        step();
        idle();
        repeat (4) step();
        checks++;
        if (got_q.size() != 3) begin
            errors++;
            $display("FAIL byte_count got %0d want 3", got_q.size());
        end else begin
            checks++;
            if (got_q[1].data !== 32'hFFFFFF80) begin
                errors++;
                $display("FAIL byte_load_sext got %h want FFFFFF80", got_q[1].data);
            end
            checks++;
            if (got_q[2].data !== 32'h80ADBEEF || got_q[0].is_store !== 1'b1) begin
                errors++;
                $display("FAIL word_after_byte got %h st=%b want 80ADBEEF st=1",
                         got_q[2].data, got_q[0].is_store);
            end
        end
    endtask

    task automatic test_fwd_order();
        rsp_t want;
        exp_q.delete(); got_q.delete();
        bus.respReady = 1'b0;
        drive(1, 0, 0, 0, 32'h10, 32'h0, 32'h0, 32'h40, 6'd5, 6'd9);
        step();
        checks++;
        if (bus.respValid !== 1'b0) begin
            errors++;
            $display("FAIL mem_load_early got v=%b want v=0", bus.respValid);
        end
        drive(1, 0, 0, 1, 32'h10, 32'h0, 32'h1234, 32'h44, 6'd6, 6'd10);
        step();
        idle();
        want = '{32'h40, 6'd5, 6'd9, 1'b0, 32'h80ADBEEF};
        checks++;
        if (bus.respValid !== 1'b1 || head_now() !== want) begin
            errors++;
            $display("FAIL fwd_first_head got v=%b %h want v=1 %h", bus.respValid, head_now(), want);
        end
        bus.respReady = 1'b1;
        step();
        want = '{32'h44, 6'd6, 6'd10, 1'b0, 32'h1234};
        checks++;
        if (bus.respValid !== 1'b1 || head_now() !== want) begin
            errors++;
            $display("FAIL fwd_second_head got v=%b %h want v=1 %h", bus.respValid, head_now(), want);
        end
        step();
        checks++;
        if (bus.respValid !== 1'b0) begin
            errors++;
            $display("FAIL fwd_drained got v=%b want v=0", bus.respValid);
        end
    endtask

    task automatic test_wrap();
        rsp_t want;
        exp_q.delete(); got_q.delete();
        bus.respReady = 1'b1;
        drive(1, 1, 0, 0, 32'h410, 32'h55, 32'h0, 32'h50, 6'd7, 6'd0);
        step();
        drive(1, 0, 0, 0, 32'h010, 32'h0, 32'h0, 32'h54, 6'd8, 6'd2);
        step();
        idle();
        step();
        want = '{32'h54, 6'd8, 6'd2, 1'b0, 32'h55};
        checks++;
        if (bus.respValid !== 1'b1 || head_now() !== want) begin
            errors++;
            $display("FAIL addr_wrap got v=%b %h want v=1 %h", bus.respValid, head_now(), want);
        end
        step();
    endtask

    task automatic test_backpressure();
        exp_q.delete(); got_q.delete();
        bus.respReady = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(0, 255)), $urandom, $urandom, $urandom,
                  6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            step();
            if (bus.respValid) begin
                checks++;
                if (exp_q.size() == 0 || head_now() !== exp_q[0]) begin
                    errors++;
                    $display("FAIL stall_head got %h want first accepted", head_now());
                end
            end
        end
        checks++;
        if (exp_q.size() != RESP_DEPTH || bus.reqReady !== 1'b0 || bus.respValid !== 1'b1) begin
            errors++;
            $display("FAIL bp_throttle got acc=%0d rdy=%b vld=%b want acc=%0d rdy=0 vld=1",
                     exp_q.size(), bus.reqReady, bus.respValid, RESP_DEPTH);
        end
        drain_all();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL bp_drain got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL bp_order[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int ng;
        exp_q.delete(); got_q.delete();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) << 10) | $urandom_range(0, 47), $urandom, $urandom,
                  $urandom, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)));
            bus.respReady = ($urandom_range(0, 3) != 0);
            step();
            ng = got_q.size();
            checks++;
            if (bus.respValid) begin
                if (ng >= exp_q.size() || head_now() !== exp_q[ng]) begin
                    errors++;
                    $display("FAIL rand_head cyc %0d got %h want entry %0d", c, head_now(), ng);
                end
            end else if (head_now() !== '0) begin
                errors++;
                $display("FAIL rand_zero cyc %0d got %h want 0", c, head_now());
            end
        end
        drain_all();
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_drain got %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_order[%0d] got %h want %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        rsp_t want;
        exp_q.delete(); got_q.delete();
        bus.respReady = 1'b0;
        drive(1, 1, 0, 0, 32'h20, 32'hCAFEF00D, 32'h0, 32'h60, 6'd11, 6'd0);
        step();
        drive(1, 1, 1, 0, 32'h30, 32'h11, 32'h0, 32'h64, 6'd12, 6'd0);
        step();
        drive(1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h68, 6'd13, 6'd1);
        step();
        idle();
        checks++;
        if (bus.respValid !== 1'b1 || bus.pcOut !== 32'h60) begin
            errors++;
            $display("FAIL pre_reset_head got v=%b pc=%h want v=1 pc=60", bus.respValid, bus.pcOut);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if (bus.respValid !== 1'b0 || head_now() !== '0 || bus.reqReady !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got v=%b head=%h rdy=%b want 0 0 0",
                     bus.respValid, head_now(), bus.reqReady);
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        bus.respReady = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (bus.respValid !== 1'b0) begin
                errors++;
                $display("FAIL stale_resp cyc %0d got v=%b pc=%h want v=0", c, bus.respValid, bus.pcOut);
            end
            step();
        end
        drive(1, 0, 0, 0, 32'h20, 32'h0, 32'h0, 32'h70, 6'd14, 6'd2);
        step();
        idle();
        step();
        want = '{32'h70, 6'd14, 6'd2, 1'b0, 32'h0};
        checks++;
        if (bus.respValid !== 1'b1 || head_now() !== want) begin
            errors++;
            $display("FAIL mem_cleared got v=%b %h want v=1 %h", bus.respValid, head_now(), want);
        end
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_byte();
        test_fwd_order();
        test_wrap();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
